// File: rtl/fir_result_streamer.sv
`default_nettype none
// ============================================================================
// Module      : fir_result_streamer
// Description : Starts the FIR core, waits for done, then streams the output
//               sample region from the sample RAM over valid/ready.
//               Optional result_checksum port: define FIR_RESULT_CHECKSUM_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module fir_result_streamer #(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 8,
    parameter int START_HOLD = 10,
    parameter int TIMEOUT    = 65535
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_out_addr,
    input  logic [ADDR_W-1:0] cmd_count,
    input  logic              cmd_pipelined,
    output logic              fir_start,
    output logic              fir_sel_pipelined,
    input  logic              fir_done,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    output logic              job_done,
    output logic              job_timeout,
    output logic [31:0]       perf_cycles
`ifdef FIR_RESULT_CHECKSUM_EN
    ,
    output logic [15:0]       result_checksum
`endif
);

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_START  = 3'd1;
    localparam logic [2:0] c_WAIT   = 3'd2;
    localparam logic [2:0] c_READ   = 3'd3;
    localparam logic [2:0] c_REPORT = 3'd4;

    logic [2:0]        r_state;
    logic [2:0]        w_next;
    logic              r_cmd_ready;
    logic [ADDR_W-1:0] r_out_addr;
    logic [ADDR_W-1:0] r_count;
    logic [ADDR_W-1:0] r_issued;
    logic              r_pipe;
    logic              r_armed;
    logic              r_tmo;
    logic [31:0]       r_cnt;
    logic [31:0]       r_perf;
    logic              r_rd_pend;
    logic              r_rd_last;

    logic [DATA_W-1:0] r_fifo_data [0:1];
    logic [1:0]        r_fifo_last;
    logic              r_wptr;
    logic              r_rptr;
    logic [1:0]        r_occ;

    logic              w_accept;
    logic              w_pop;
    logic              w_head_last;
    logic [2:0]        w_slots;
    logic              w_room;
    logic              w_issue;
    logic              w_done_seen;
    logic              w_hold_end;
    logic              w_tmo_hit;

    assign w_accept    = cmd_valid && r_cmd_ready;
    assign w_pop       = (r_occ != 2'd0) && m_ready;
    assign w_head_last = r_fifo_last[r_rptr];
    // A beat leaving this cycle frees its slot, which keeps one read per cycle
    assign w_slots     = {1'b0, r_occ} + {2'b00, r_rd_pend} - {2'b00, w_pop};
    assign w_room      = w_slots < 3'd2;
    assign w_issue     = (r_state == c_READ) && (r_issued != r_count) && w_room;
    assign w_done_seen = r_armed && fir_done;
    assign w_hold_end  = r_cnt == 32'(START_HOLD - 1);
    assign w_tmo_hit   = r_cnt >= 32'(TIMEOUT - 1);

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE:   if (w_accept) w_next = c_START;
            c_START:  if (w_hold_end) w_next = c_WAIT;
            c_WAIT: begin
                if (w_done_seen)    w_next = c_READ;
                else if (w_tmo_hit) w_next = c_REPORT;
            end
            c_READ: begin
                if (r_count == '0)                  w_next = c_REPORT;
                else if (w_pop && w_head_last)      w_next = c_REPORT;
            end
            c_REPORT: w_next = c_IDLE;
            default:  w_next = c_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_IDLE;
            r_cmd_ready <= 1'b0;
            r_out_addr  <= '0;
            r_count     <= '0;
            r_issued    <= '0;
            r_pipe      <= 1'b0;
            r_armed     <= 1'b0;
            r_tmo       <= 1'b0;
            r_cnt       <= '0;
            r_perf      <= '0;
            r_rd_pend   <= 1'b0;
            r_rd_last   <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_cmd_ready <= (w_next == c_IDLE);
            r_rd_pend   <= w_issue;
            if (w_issue) begin
                r_issued  <= r_issued + ADDR_W'(1);
                r_rd_last <= (r_issued == r_count - ADDR_W'(1));
            end
            if (w_accept) begin
                r_out_addr <= cmd_out_addr;
                r_count    <= cmd_count;
                r_pipe     <= cmd_pipelined;
                r_issued   <= '0;
                r_armed    <= 1'b0;
                r_tmo      <= 1'b0;
                r_cnt      <= '0;
            end
            // A done seen before any low sample is left over from the last job
            if ((r_state == c_START || r_state == c_WAIT) && !fir_done)
                r_armed <= 1'b1;
            if (r_state == c_START)
                r_cnt <= r_cnt + 32'd1;
            if (r_state == c_WAIT && !w_done_seen) begin
                r_cnt <= r_cnt + 32'd1;
                if (w_tmo_hit) r_tmo <= 1'b1;
            end
            if (r_state == c_REPORT)
                r_perf <= r_cnt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fifo_data[0] <= '0;
            r_fifo_data[1] <= '0;
            r_fifo_last    <= '0;
            r_wptr         <= 1'b0;
            r_rptr         <= 1'b0;
            r_occ          <= '0;
        end else begin
            if (r_rd_pend) begin
                r_fifo_data[r_wptr] <= mem_rdata;
                r_fifo_last[r_wptr] <= r_rd_last;
                r_wptr              <= ~r_wptr;
            end
            if (w_pop)
                r_rptr <= ~r_rptr;
            r_occ <= r_occ + {1'b0, r_rd_pend} - {1'b0, w_pop};
        end
    end

`ifdef FIR_RESULT_CHECKSUM_EN
    logic [15:0] r_csum;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_csum <= '0;
        else if (w_accept)
            r_csum <= '0;
        else if (w_pop)
            r_csum <= r_csum + 16'($signed(m_data));
    end

    assign result_checksum = r_csum;
`endif

    assign cmd_ready         = r_cmd_ready;
    assign fir_start         = (r_state == c_START);
    assign fir_sel_pipelined = r_pipe;
    assign mem_en            = w_issue;
    assign mem_addr          = w_issue ? (r_out_addr + r_issued) : '0;
    assign m_valid           = (r_occ != 2'd0);
    assign m_data            = r_fifo_data[r_rptr];
    assign m_last            = m_valid && w_head_last;
    assign job_done          = (r_state == c_REPORT);
    assign job_timeout       = (r_state == c_REPORT) && r_tmo;
    assign perf_cycles       = r_perf;

endmodule
`default_nettype wire

// File: doc/fir_result_streamer.md
Name: fir_result_streamer

Overview:
Hardware initiator and result reader for the FIR engine. It accepts a job command, drives the FIR core's start/sel_pipelined controls, and waits for done while counting cycles. When the core finishes, it reads the output sample region back from the shared sample RAM read port and streams the samples out on a valid/ready interface. It replaces the bench-driven start/wait/readback sequence with synthesizable logic, so it sits between the system controller and fir_top.

Parameters:
ADDR_W, 10, sample RAM address width
DATA_W, 8, sample width (signed)
START_HOLD, 10, cycles fir_start is held high (>=1)
TIMEOUT, 65535, max cycles waiting for fir_done before aborting

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
cmd_valid  in  1  job command valid
cmd_ready  out  1  block can accept a command (high only in IDLE)
cmd_out_addr  in  ADDR_W  first output-sample address
cmd_count  in  ADDR_W  number of samples to read back (0 allowed)
cmd_pipelined  in  1  selects the pipelined FIR
fir_start  out  1  start to FIR core
fir_sel_pipelined  out  1  datapath select to FIR core
fir_done  in  1  level done from FIR core
mem_en  out  1  RAM read enable
mem_addr  out  ADDR_W  RAM read address
mem_rdata  in  DATA_W  RAM read data, valid exactly 1 cycle after mem_en
m_valid  out  1  output sample valid
m_ready  in  1  downstream ready
m_data  out  DATA_W  output sample
m_last  out  1  marks the final sample of a job
job_done  out  1  one-cycle pulse at end of job
job_timeout  out  1  one-cycle pulse, coincident with job_done, when the job aborted
perf_cycles  out  32  cycles from the first fir_start cycle to fir_done observed; held until the next job

Behaviour:
- Reset values: cmd_ready=0 during reset, then 1 in IDLE. All other outputs are 0, perf_cycles=0, state=IDLE. Reset mid-job aborts immediately: no job_done, output FIFO flushed.
- Handshake: a command is latched on cmd_valid&&cmd_ready. cmd_* fields are registered, and fir_sel_pipelined is driven from the latched value for the whole job.
- IDLE -> START on handshake.
- START: fir_start=1 for exactly START_HOLD cycles, then -> WAIT_DONE. perf counter cleared on the first START cycle, incremented every cycle through WAIT_DONE.
- WAIT_DONE arming rule: the block must first sample fir_done=0 at least once after START begins. After arming, fir_done=1 -> READ. This rejects a stale done left high from the previous job.
- WAIT_DONE timeout: if the counter reaches TIMEOUT in WAIT_DONE -> REPORT with the timeout flag set and no samples streamed.
- READ: issue addresses cmd_out_addr+i, i=0..cmd_count-1. Address arithmetic is modulo 2^ADDR_W, so 1023 wraps to 0.
- Output buffer: a 2-entry FIFO. A read is issued only when (FIFO occupancy + reads in flight) < 2, so no data is ever dropped under m_ready backpressure. Throughput is 1 sample/cycle while m_ready=1.
- m_valid=1 whenever the FIFO is non-empty. m_data/m_last stay stable while m_valid&&!m_ready.
- m_last=1 on the sample with index cmd_count-1. If cmd_count=0, no samples are produced and READ -> REPORT directly.
- READ -> REPORT once the last sample is accepted (m_valid&&m_ready&&m_last).
- REPORT: job_done=1 for one cycle, job_timeout=flag, latch perf_cycles -> IDLE.
- fir_done changes during READ are ignored.

Optional Feature:
FIR_RESULT_CHECKSUM_EN
- Defined: adds output port result_checksum (16 bits). It is cleared on command accept and accumulates the sign-extended m_data on every accepted beat, modulo 2^16. It is valid and held from job_done onward.
- Undefined: the port and the adder are absent; all other behaviour is identical.

Test Plan:
- Setup for basic job: RAM[256..275] = sine samples (period 40, amplitude 64); fir_done model pulses high 150 cycles after start falls.
- Basic job: cmd(out=256, count=20, pipelined=0), m_ready=1 -> fir_start high exactly 10 cycles; 20 beats equal to RAM[256..275]; m_last on beat 20; job_done; perf_cycles=160.
- Stale done: fir_done held high from the previous job; issue a new cmd -> the block waits for fir_done low->high and does not read early; perf_cycles reflects the new run only.
- Backpressure: count=20, m_ready toggling 1,0,0,1 -> exactly 20 beats in order, no duplicates or loss; m_data stable while stalled.
- Wrap and empty job: out=1020, count=8 -> addresses 1020..1023,0..3. A separate count=0 job -> no m_valid, job_done is the only response.
- Timeout and reset: TIMEOUT=200, fir_done stuck 0 -> job_done and job_timeout pulse together at cycle 200, zero beats. Asserting rst mid-READ -> all outputs 0 at once, then cmd_ready=1 after rst falls.
